// File: rtl/highpass_pkg.sv
// Shared types and helpers for the highpass filter block.
// Holds the FSM state enum, the accumulator width rule and the output clamp.
// Pure declarations: no state, no timing, no handshake.
package highpass_pkg;

    typedef enum logic [1:0] {
        PRIME  = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } hp_state_t;

    // One guard bit above WIDTH+L2_ALPHA keeps sum + u - lp from overflowing.
    function automatic int sum_width(input int width, input int l2_alpha);
        return width + l2_alpha + 1;
    endfunction

    // Clamp a signed value into the two's complement range of 'width' bits.
    // The caller truncates the result to 'width' bits.
    function automatic logic signed [63:0] sat_resize(input logic signed [63:0] x,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        return x;
    endfunction

endpackage

// File: rtl/highpass_accum.sv
// hp_accum: leaky-integrator state (sum), its lowpass tap and the highpass difference.
// Latency: sum updates on the clock after load/upd; y_full is combinational from u and sum.
// Backpressure: none of its own; the top only pulses load/upd on an accepted sample.
// Ports: clk, clr (sync zero), load (prime sum from u), upd (integrate u), u, y_full.
module hp_accum
    import highpass_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int L2_ALPHA = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    load,
    input  logic                    upd,
    input  logic signed [WIDTH-1:0] u,
    output logic signed [WIDTH:0]   y_full
);

    localparam int SW = sum_width(WIDTH, L2_ALPHA);

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] lp;
    logic signed [SW-1:0] u_sx;
    logic signed [SW-1:0] sum_nxt;

    // Floor division by 2^L2_ALPHA.
    assign lp      = sum >>> L2_ALPHA;
    assign u_sx    = {{(L2_ALPHA + 1){u[WIDTH-1]}}, u};
    assign sum_nxt = sum + u_sx - lp;

    // lp is a weighted average of past inputs, so it always fits WIDTH+1 bits.
    assign y_full  = {u[WIDTH-1], u} - lp[WIDTH:0];

    always_ff @(posedge clk) begin
        if (clr)
            sum <= '0;
        else if (load)
            // Priming makes lp equal to the first sample, so the first
            // difference starts near zero instead of a full-scale step.
            sum <= {u[WIDTH-1], u, {L2_ALPHA{1'b0}}};
        else if (upd)
            sum <= sum_nxt;
    end

endmodule

// File: rtl/highpass.sv
// highpass: streaming DC-blocking filter y = u - LP(u) with priming and settle flag.
// Latency 1 cycle from accept to y; 1 sample/clock under continuous flow.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output freezes all state.
// Ports: clk, rst (sync, active-high), clear, in_valid/in_ready/u, out_valid/out_ready/y, settled.
// Build option: HIGHPASS_SAT_EN clamps y to the WIDTH-bit range instead of wrapping.
module highpass
    import highpass_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int L2_ALPHA     = 4,
    parameter int SETTLE_COUNT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] u,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] y,
    output logic                    settled
);

    localparam int CW = $clog2(SETTLE_COUNT + 1);

    hp_state_t               state;
    hp_state_t               state_nxt;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic                    settled_nxt;
    logic                    accept;
    logic                    load;
    logic                    upd;
    logic signed [WIDTH:0]   y_full;
    logic signed [WIDTH-1:0] y_res;
    logic signed [WIDTH-1:0] y_nxt;

    assign in_ready = !rst && (!out_valid || out_ready);
    // A sample offered during clear is consumed by the handshake but dropped.
    assign accept   = in_valid && in_ready && !clear;
    assign load     = accept && (state == PRIME);
    assign upd      = accept && (state != PRIME);

    hp_accum #(
        .WIDTH    (WIDTH),
        .L2_ALPHA (L2_ALPHA)
    ) u_acc (
        .clk    (clk),
        .clr    (rst || clear),
        .load   (load),
        .upd    (upd),
        .u      (u),
        .y_full (y_full)
    );

`ifdef HIGHPASS_SAT_EN
    assign y_res = WIDTH'(sat_resize(64'(y_full), WIDTH));
`else
    assign y_res = y_full[WIDTH-1:0];
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        settled_nxt = settled;
        y_nxt       = y_res;
        if (accept) begin
            case (state)
                PRIME: begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                    y_nxt     = '0;
                end
                SETTLE: begin
                    if (cnt != CW'(SETTLE_COUNT))
                        cnt_nxt = cnt + 1'b1;
                    if (cnt_nxt == CW'(SETTLE_COUNT)) begin
                        state_nxt   = RUN;
                        settled_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= PRIME;
            cnt       <= '0;
            settled   <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            settled <= settled_nxt;
            if (accept) begin
                y         <= y_nxt;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_highpass.sv
// Directed bench for highpass (WIDTH=16, L2_ALPHA=4, SETTLE_COUNT=64).
module tb_highpass;
    import highpass_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] u;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] y;
    logic               settled;

    int errors = 0;
    int checks = 0;

    highpass #(.WIDTH(16), .L2_ALPHA(4), .SETTLE_COUNT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .u         (u),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .settled   (settled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] u;
        logic signed [15:0] y;
        logic               s;
    } vec_t;

    vec_t step_tbl [5];

    // Outputs captured at each handshake while enabled.
    logic signed [15:0] mon_q [$];
    logic               mon_en = 1'b0;
    always @(posedge clk)
        if (mon_en && out_valid && out_ready)
            mon_q.push_back(y);

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Offer one sample with out_ready=1, then check the registered result.
    task automatic send(input logic signed [15:0] uv, input logic signed [15:0] ey,
                        input logic es, input string nm);
        int n;
        n         = 0;
        in_valid  = 1'b1;
        u         = uv;
        out_ready = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready)
            chk({nm, "_ready_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_y"}, y, ey);
        chk({nm, "_settled"}, settled, es);
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin : main
        logic signed [15:0] bp_u [6];
        logic signed [15:0] bp_y [6];
        logic signed [15:0] y_hold;
        logic               rdy;
        int                 idx;

        step_tbl[0] = '{u: 16'sd0,    y: 16'sd0,    s: 1'b0};
        step_tbl[1] = '{u: 16'sd1000, y: 16'sd1000, s: 1'b0};
        step_tbl[2] = '{u: 16'sd1000, y: 16'sd938,  s: 1'b0};
        step_tbl[3] = '{u: 16'sd1000, y: 16'sd879,  s: 1'b0};
        step_tbl[4] = '{u: 16'sd1000, y: 16'sd824,  s: 1'b0};
        bp_u = '{16'sd0, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000};
        bp_y = '{16'sd0, 16'sd1000, 16'sd938, 16'sd879, 16'sd824, 16'sd773};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; u = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_y", y, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_settled", settled, 0);
        rst = 1'b0;

        // Step response from reset.
        for (int i = 0; i < 5; i++) begin
            send(step_tbl[i].u, step_tbl[i].y, step_tbl[i].s, $sformatf("step%0d", i));
            if (i == 1)
                chk("step_sum", dut.u_acc.sum, 1000);
        end

        // Full-scale jump: +32767 after priming at -32768 gives y_full = 65535.
        do_clear();
        send(-16'sd32768, 16'sd0, 1'b0, "sat_prime");
`ifdef HIGHPASS_SAT_EN
        send(16'sd32767, 16'sd32767, 1'b0, "sat_jump");
`else
        send(16'sd32767, -16'sd1, 1'b0, "sat_jump");
`endif

        // Backpressure: 5 stalled cycles in the middle of a 6-sample stream.
        do_clear();
        mon_q.delete();
        mon_en = 1'b1;
        idx    = 0;
        y_hold = '0;
        for (int cyc = 0; cyc < 40 && (idx < 6 || out_valid); cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = (idx < 6);
            u         = (idx < 6) ? bp_u[idx] : 16'sd0;
            #1;
            if (cyc == 3) begin
                y_hold = y;
                chk("bp_stall_valid", out_valid, 1);
            end
            if (cyc >= 3 && cyc < 8) begin
                chk($sformatf("bp_stall_ready%0d", cyc), in_ready, 0);
                chk($sformatf("bp_stall_y%0d", cyc), y, y_hold);
            end else if (idx < 6) begin
                chk($sformatf("bp_flow_ready%0d", cyc), in_ready, 1);
            end
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy)
                idx++;
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        mon_en = 1'b0;
        chk("bp_accepted", idx, 6);
        chk("bp_out_count", mon_q.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("bp_out%0d", i), (i < mon_q.size()) ? mon_q[i] : 16'sh7abc, bp_y[i]);

        // Priming with a constant: every y is zero, settled rises on output 65.
        do_clear();
        for (int i = 1; i <= 65; i++)
            send(-16'sd5000, 16'sd0, (i == 65), $sformatf("prime%0d", i));

        // Clear together with an accept in RUN: the 1000 must be dropped.
        clear     = 1'b1;
        in_valid  = 1'b1;
        u         = 16'sd1000;
        out_ready = 1'b1;
        #1;
        chk("clr_ready", in_ready, 1);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_settled", settled, 0);
        @(posedge clk);
        #1;
        chk("clr_no_ghost", out_valid, 0);
        send(16'sd777, 16'sd0, 1'b0, "clr_prime");
        send(16'sd777, 16'sd0, 1'b0, "clr_hold");
        send(16'sd1000, 16'sd223, 1'b0, "clr_step");

        // Reset in SETTLE with a stalled, valid output.
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        u         = 16'sd500;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("rstb_pending", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rstb_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstb_y", y, 0);
        chk("rstb_out_valid", out_valid, 0);
        chk("rstb_settled", settled, 0);
        chk("rstb_state", int'(dut.state), int'(PRIME));
        send(16'sd42, 16'sd0, 1'b0, "rstb_prime");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/highpass.md
# highpass

Streaming first-order DC-blocking highpass filter, y = u − LP(u), with LP the same leaky integrator used by the team's lowpass (α = 2^−L2_ALPHA). It sits between a signed sample source and downstream consumers that need the offset removed. Data moves on a valid/ready handshake. Startup priming avoids the large initial transient, and a settle counter flags when the output is trustworthy.

## Interface
- WIDTH, 16: sample width, two's complement, for both input and output.
- L2_ALPHA, 4: log2 of the integrator time constant, ≥1.
- SETTLE_COUNT, 64: number of accepted samples after priming before `settled` asserts, ≥1.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous restart of the filter; returns it to priming.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- u  in  WIDTH  signed input sample.
- out_valid  out  1  y holds a result.
- out_ready  in  1  downstream accepts y when out_valid && out_ready.
- y  out  WIDTH  signed highpass output, registered.
- settled  out  1  high once SETTLE_COUNT samples have been processed after priming.

## Operation
- Accumulator `sum`: signed, SUM_WIDTH = WIDTH + L2_ALPHA + 1 bits. lp = sum >>> L2_ALPHA (arithmetic shift, floor).
- FSM states: PRIME, SETTLE, RUN.
  - PRIME: the first accepted sample loads sum ← u <<< L2_ALPHA and emits y = 0. Then → SETTLE with the counter cleared.
  - SETTLE and RUN: on each accepted sample, y_full = u − lp (WIDTH+1 bits, using lp before the update). sum ← sum + sext(u) − sext(lp). y ← y_full reduced to WIDTH (see Configuration).
  - SETTLE: counter increments on each accepted sample. When the count reaches SETTLE_COUNT → RUN and settled ← 1. The counter saturates and does not wrap.
- settled is 0 in PRIME and SETTLE, and 1 in RUN.
- clear: state → PRIME, sum ← 0, counter ← 0, settled ← 0, out_valid ← 0 (any pending result is discarded). If clear and an accept occur in the same cycle, clear wins and the sample is dropped.
- rst: same effect as clear. Reset values: y = 0, out_valid = 0, settled = 0, sum = 0, state = PRIME.

## Timing
- One output register. in_ready = !out_valid || out_ready (combinational, no bubble under continuous flow).
- Latency: y is valid 1 cycle after the sample is accepted. Throughput is 1 sample/clock.
- While out_valid && !out_ready: y and out_valid hold stable, in_ready = 0, and no state changes.
- settled updates in the same cycle that the result which completes SETTLE_COUNT is registered.
- in_ready is 0 during a cycle with rst asserted. in_ready during clear follows the equation above, but a sample accepted in a clear cycle is dropped.

## Configuration
- HIGHPASS_SAT_EN defined: y_full outside the range [−2^(WIDTH−1), 2^(WIDTH−1)−1] clamps to the nearest bound.
- HIGHPASS_SAT_EN undefined: y = y_full[WIDTH−1:0] (wrap). No clamp logic is instantiated.
- The accumulator never saturates in either build; SUM_WIDTH guarantees no overflow.

## Structure
- Package `highpass_pkg`:
  - state enum hp_state_t {PRIME, SETTLE, RUN};
  - function computing SUM_WIDTH;
  - saturating-resize function used under HIGHPASS_SAT_EN.
- Sub-module `hp_accum`: holds sum, lp, and the next-sum/y_full arithmetic, with a load (prime) input and an update enable. The top level holds the FSM, counter, handshake, and output register.

## Test plan
- Step response (WIDTH=16, L2_ALPHA=4):
  - Stimulus: prime with u=0, then u=1000 repeatedly.
  - Required: y = 0, 1000, 938, 879, … (lp = 0, 62, 121). sum after the first step sample = 1000.
- Priming:
  - Stimulus: constant u=−5000 from reset.
  - Required: y = 0 on every output. settled rises exactly on the 65th output (1 prime + 64).
- Saturation (WIDTH=8, L2_ALPHA=4):
  - Stimulus: prime with −128, then u=127.
  - Required: y = 127 with HIGHPASS_SAT_EN, y = −1 without it.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles with in_valid=1.
  - Required: in_ready=0, y stable, no sample lost. Each sample appears exactly once after release, with a continuous 1/clk stream.
- Clear:
  - Stimulus: assert clear mid-stream, simultaneous with an accept.
  - Required: out_valid=0 and settled=0 next cycle. The dropped sample never appears. The next accepted sample primes and gives y=0.
- Reset:
  - Stimulus: assert rst during SETTLE with out_valid=1 and out_ready=0.
  - Required: next cycle y=0, out_valid=0, settled=0, state PRIME.
